mprj_io_pad_ctrl: RTL and testbench

Core-side controller for the user-project pad array. Holds a per-pad configuration loaded over a serial chain and drives the pad array's `io_out`, `oeb`, `inp_dis` and `dm` buses. Each pad's output path is selected between management and user sources. Pad inputs (`io_in`) are synchronized back to the management domain. The block sits between housekeeping/user logic and the pad ring, and is the driving end of the ring's control interface.

---
 rtl/mprj_io_pkg.sv | 24 ++
 rtl/mprj_io_sync2.sv | 30 +++
 rtl/mprj_io_pad_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mprj_io_pad_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_io_pkg.sv
// mprj_io_pkg: shared definitions for the user-project pad controller.
//   CFG_W         width of one pad's configuration word
//   CFG_*         field positions inside a pad configuration word
//   CFG_RST       per-pad configuration after reset
//   cfg_state_e   serial-loader FSM states
package mprj_io_pkg;

    localparam int CFG_W       = 6;
    localparam int CFG_MGMT_EN = 0;
    localparam int CFG_OEB     = 1;
    localparam int CFG_INP_DIS = 2;
    localparam int CFG_DM_LO   = 3;
    localparam int CFG_DM_HI   = 5;

    // Management-owned, output disabled, input enabled, dm = 001.
    localparam logic [CFG_W-1:0] CFG_RST = 6'h0B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no bits collected since last load/capture/reset
        ST_SHIFT = 2'd1,   // partial stream in the shadow register
        ST_FULL  = 2'd2    // at least TOTAL_BITS bits collected
    } cfg_state_e;

endpackage

// File: rtl/mprj_io_sync2.sv
// mprj_io_sync2: W-bit two-flop synchronizer, asynchronous active-high reset to 0.
//   i_clk  clock of the destination domain
//   i_rst  asynchronous active-high reset
//   i_d    asynchronous input bus
//   o_q    synchronized bus, two cycles of latency
module mprj_io_sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/mprj_io_pad_ctrl.sv
// mprj_io_pad_ctrl: core-side controller for the user-project pad array.
// A 6-bit config per pad is shifted into a shadow register over a serial
// chain and committed to the active config with ser_load once the full
// stream (6*TOTAL_PADS bits) has arrived. The active config drives the pad
// ring's io_out/oeb/inp_dis/dm buses and selects management or user sources.
//
// Optional feature macro: MPRJ_IO_PAD_CTRL_READBACK_EN adds ser_capture,
// which copies the active config into the shadow register for shift-out.
//
// Ports:
//   clock, reset                   clock / async active-high reset
//   ser_data_in, ser_shift         serial config bit and shift enable
//   ser_load                       commit shadow -> active (only when FULL)
//   ser_capture                    active -> shadow (readback builds only)
//   ser_data_out                   shadow MSB (chain out / readback)
//   cfg_busy                       high while in SHIFT
//   cfg_applied, area1_cfg_applied load-success pulses
//   cfg_err                        load-rejected pulse
//   mgmt_gpio_out/oeb, user_io_out/oeb   output sources
//   mgmt_gpio_in                   io_in synchronized (2 cycles)
//   user_io_in                     io_in passthrough
//   io_in, io_out, oeb, inp_dis, dm      pad ring interface
module mprj_io_pad_ctrl
    import mprj_io_pkg::*;
#(
    parameter int TOTAL_PADS = 38,
    parameter int AREA1PADS  = 19
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ser_data_in,
    input  logic                    ser_shift,
    input  logic                    ser_load,
`ifdef MPRJ_IO_PAD_CTRL_READBACK_EN
    input  logic                    ser_capture,
`endif
    output logic                    ser_data_out,
    output logic                    cfg_busy,
    output logic                    cfg_applied,
    output logic                    area1_cfg_applied,
    output logic                    cfg_err,
    input  logic [TOTAL_PADS-1:0]   mgmt_gpio_out,
    input  logic [TOTAL_PADS-1:0]   mgmt_gpio_oeb,
    input  logic [TOTAL_PADS-1:0]   user_io_out,
    input  logic [TOTAL_PADS-1:0]   user_io_oeb,
    output logic [TOTAL_PADS-1:0]   mgmt_gpio_in,
    output logic [TOTAL_PADS-1:0]   user_io_in,
    input  logic [TOTAL_PADS-1:0]   io_in,
    output logic [TOTAL_PADS-1:0]   io_out,
    output logic [TOTAL_PADS-1:0]   oeb,
    output logic [TOTAL_PADS-1:0]   inp_dis,
    output logic [3*TOTAL_PADS-1:0] dm
);

    localparam int                TOTAL_BITS = CFG_W * TOTAL_PADS;
    localparam int                CNT_W      = $clog2(TOTAL_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TOTAL_BITS);

    // Shadow and active config share the packing: pad i at bits [6i+5:6i].
    logic [TOTAL_BITS-1:0]               r_shadow;
    logic [TOTAL_PADS-1:0][CFG_W-1:0]    r_cfg;
    logic [TOTAL_PADS-1:0][CFG_W-1:0]    w_shadow_cfg;
    logic [CNT_W-1:0]                    r_count;
    cfg_state_e                          r_state;

    logic                                r_applied;
    logic                                r_area1_applied;
    logic                                r_err;

    logic                                w_capture;
    cfg_state_e                          w_nxt_state;
    logic [CNT_W-1:0]                    w_nxt_count;
    logic                                w_load_ok;
    logic                                w_load_err;
    logic                                w_do_shift;
    logic                                w_do_capture;
    logic                                w_area1_diff;

`ifdef MPRJ_IO_PAD_CTRL_READBACK_EN
    assign w_capture = ser_capture;
`else
    assign w_capture = 1'b0;
`endif

    assign w_shadow_cfg = r_shadow;
    assign w_area1_diff = (w_shadow_cfg[AREA1PADS-1:0] != r_cfg[AREA1PADS-1:0]);

    // ---------------------------------------------------------------
    // Loader FSM. Priority: load > capture > shift. A load always clears
    // the count, so a shift bit arriving with it is discarded.
    // ---------------------------------------------------------------
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_count  = r_count;
        w_load_ok    = 1'b0;
        w_load_err   = 1'b0;
        w_do_shift   = 1'b0;
        w_do_capture = 1'b0;
        if (ser_load) begin
            if (r_state == ST_FULL) w_load_ok  = 1'b1;
            else                    w_load_err = 1'b1;
            w_nxt_count = '0;
            w_nxt_state = ST_IDLE;
        end else if (w_capture) begin
            w_do_capture = 1'b1;
            w_nxt_count  = '0;
            w_nxt_state  = ST_IDLE;
        end else if (ser_shift) begin
            w_do_shift = 1'b1;
            // Count saturates; extra shifts keep the most recent TOTAL_BITS bits.
            if (r_count != CNT_MAX) w_nxt_count = r_count + 1'b1;
            w_nxt_state = (w_nxt_count == CNT_MAX) ? ST_FULL : ST_SHIFT;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_count <= w_nxt_count;
        end
    end

    // Shadow register, active config and status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow        <= '0;
            r_cfg           <= {TOTAL_PADS{CFG_RST}};
            r_applied       <= 1'b0;
            r_area1_applied <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_applied       <= w_load_ok;
            r_area1_applied <= w_load_ok & w_area1_diff;
            r_err           <= w_load_err;
            if (w_load_ok)
                r_cfg <= w_shadow_cfg;
            if (w_do_capture)
                r_shadow <= r_cfg;
            else if (w_do_shift)
                r_shadow <= {r_shadow[TOTAL_BITS-2:0], ser_data_in};
        end
    end

    assign ser_data_out      = r_shadow[TOTAL_BITS-1];
    assign cfg_busy          = (r_state == ST_SHIFT);
    assign cfg_applied       = r_applied;
    assign area1_cfg_applied = r_area1_applied;
    assign cfg_err           = r_err;

    // ---------------------------------------------------------------
    // Per-pad output mux: config's oeb bit can force the pad off
    // regardless of which source owns it.
    // ---------------------------------------------------------------
    for (genvar i = 0; i < TOTAL_PADS; i++) begin : g_pad
        always_comb begin
            if (r_cfg[i][CFG_MGMT_EN]) begin
                io_out[i] = mgmt_gpio_out[i];
                oeb[i]    = mgmt_gpio_oeb[i] | r_cfg[i][CFG_OEB];
            end else begin
                io_out[i] = user_io_out[i];
                oeb[i]    = user_io_oeb[i] | r_cfg[i][CFG_OEB];
            end
        end
        assign inp_dis[i]     = r_cfg[i][CFG_INP_DIS];
        assign dm[3*i +: 3]   = r_cfg[i][CFG_DM_HI:CFG_DM_LO];
    end

    // Pad inputs back to the management domain.
    mprj_io_sync2 #(
        .W (TOTAL_PADS)
    ) u_sync_in (
        .i_clk (clock),
        .i_rst (reset),
        .i_d   (io_in),
        .o_q   (mgmt_gpio_in)
    );

    assign user_io_in = io_in;

endmodule

// File: tb/tb_mprj_io_pad_ctrl.sv
module tb_mprj_io_pad_ctrl;

    localparam int NP = 4;
    localparam int NB = 24;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            ser_data_in = 1'b0;
    logic            ser_shift = 1'b0;
    logic            ser_load = 1'b0;
`ifdef MPRJ_IO_PAD_CTRL_READBACK_EN
    logic            ser_capture = 1'b0;
`endif
    logic            ser_data_out, cfg_busy, cfg_applied, area1_cfg_applied, cfg_err;
    logic [NP-1:0]   mgmt_gpio_out = 4'hA;
    logic [NP-1:0]   mgmt_gpio_oeb = 4'h0;
    logic [NP-1:0]   user_io_out   = 4'h5;
    logic [NP-1:0]   user_io_oeb   = 4'h2;
    logic [NP-1:0]   mgmt_gpio_in, user_io_in, io_out, oeb, inp_dis;
    logic [NP-1:0]   io_in = 4'h0;
    logic [3*NP-1:0] dm;

    int n_cmp = 0;
    int n_bad = 0;

    mprj_io_pad_ctrl #(.TOTAL_PADS(NP), .AREA1PADS(2)) dut (
        .clock             (clock),
        .reset             (reset),
        .ser_data_in       (ser_data_in),
        .ser_shift         (ser_shift),
        .ser_load          (ser_load),
`ifdef MPRJ_IO_PAD_CTRL_READBACK_EN
        .ser_capture       (ser_capture),
`endif
        .ser_data_out      (ser_data_out),
        .cfg_busy          (cfg_busy),
        .cfg_applied       (cfg_applied),
        .area1_cfg_applied (area1_cfg_applied),
        .cfg_err           (cfg_err),
        .mgmt_gpio_out     (mgmt_gpio_out),
        .mgmt_gpio_oeb     (mgmt_gpio_oeb),
        .user_io_out       (user_io_out),
        .user_io_oeb       (user_io_oeb),
        .mgmt_gpio_in      (mgmt_gpio_in),
        .user_io_in        (user_io_in),
        .io_in             (io_in),
        .io_out            (io_out),
        .oeb               (oeb),
        .inp_dis           (inp_dis),
        .dm                (dm)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_shift   = 1'b1;
        ser_data_in = b;
        tick();
        ser_shift   = 1'b0;
    endtask

    task automatic send_word(input logic [NB-1:0] w);
        for (int k = NB - 1; k >= 0; k--) send_bit(w[k]);
    endtask

    task automatic pulse_load();
        ser_load = 1'b1;
        tick();
        ser_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (oeb !== 4'hF) begin n_bad++; $display("FAIL reset_oeb got=%h want=F", oeb); end
        n_cmp++; if (dm !== 12'h249) begin n_bad++; $display("FAIL reset_dm got=%h want=249", dm); end
        n_cmp++; if (inp_dis !== 4'h0) begin n_bad++; $display("FAIL reset_inp_dis got=%h want=0", inp_dis); end
        n_cmp++; if (io_out !== 4'hA) begin n_bad++; $display("FAIL reset_io_out got=%h want=A", io_out); end
        n_cmp++;
        if ({cfg_busy, cfg_applied, area1_cfg_applied, cfg_err, ser_data_out} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_status got=%b want=00000",
                     {cfg_busy, cfg_applied, area1_cfg_applied, cfg_err, ser_data_out});
        end
        n_cmp++; if (mgmt_gpio_in !== 4'h0) begin n_bad++; $display("FAIL reset_mgmt_in got=%h want=0", mgmt_gpio_in); end
        reset = 1'b0;
        tick();
    endtask

    // pad3 handed to user, pads 2..0 keep reset config.
    task automatic test_load_ok();
        send_bit(1'b0);
        n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_1 got=%b want=1", cfg_busy); end
        send_word({6'h00, 6'h0B, 6'h0B, 6'h0B} << 0 >> 0);
        // 25 bits sent; the last 24 are the word above (first bit dropped).
        n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL busy_full got=%b want=0", cfg_busy); end
        pulse_load();
        n_cmp++; if (cfg_applied !== 1'b1) begin n_bad++; $display("FAIL applied got=%b want=1", cfg_applied); end
        n_cmp++; if (area1_cfg_applied !== 1'b0) begin n_bad++; $display("FAIL area1_none got=%b want=0", area1_cfg_applied); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_on_ok got=%b want=0", cfg_err); end
        n_cmp++; if (io_out !== 4'b0010) begin n_bad++; $display("FAIL user_io_out got=%b want=0010", io_out); end
        n_cmp++; if (oeb !== 4'b0111) begin n_bad++; $display("FAIL user_oeb got=%b want=0111", oeb); end
        n_cmp++; if (dm !== 12'h049) begin n_bad++; $display("FAIL user_dm got=%h want=049", dm); end
        tick();
        n_cmp++; if (cfg_applied !== 1'b0) begin n_bad++; $display("FAIL applied_pulse got=%b want=0", cfg_applied); end
        user_io_out = 4'hF;
        #1;
        n_cmp++; if (io_out !== 4'b1010) begin n_bad++; $display("FAIL user_follow got=%b want=1010", io_out); end
    endtask

    task automatic test_load_err();
        for (int k = 0; k < 10; k++) send_bit(1'b1);
        n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL busy_partial got=%b want=1", cfg_busy); end
        pulse_load();
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err got=%b want=1", cfg_err); end
        n_cmp++; if (cfg_applied !== 1'b0) begin n_bad++; $display("FAIL applied_on_err got=%b want=0", cfg_applied); end
        n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_err got=%b want=0", cfg_busy); end
        n_cmp++;
        if ({io_out, oeb, dm} !== {4'b1010, 4'b0111, 12'h049}) begin
            n_bad++;
            $display("FAIL err_unchanged got=%b/%b/%h want=1010/0111/049", io_out, oeb, dm);
        end
        tick();
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse got=%b want=0", cfg_err); end
    endtask

    // 30 bits: 6-bit prefix then the config that must win.
    task automatic test_overshift();
        logic [29:0] s;
        s = {6'b101101, 6'h0B, 6'h0B, 6'h06, 6'h19};
        for (int n = 0; n < 30; n++) begin
            send_bit(s[29-n]);
            if (n >= 23 && n <= 28) begin
                n_cmp++;
                if (ser_data_out !== s[29-(n-23)]) begin
                    n_bad++;
                    $display("FAIL sdo_prefix[%0d] got=%b want=%b", n - 23, ser_data_out, s[29-(n-23)]);
                end
            end
        end
        pulse_load();
        n_cmp++; if (cfg_applied !== 1'b1) begin n_bad++; $display("FAIL applied30 got=%b want=1", cfg_applied); end
        n_cmp++; if (area1_cfg_applied !== 1'b1) begin n_bad++; $display("FAIL area1 got=%b want=1", area1_cfg_applied); end
        n_cmp++; if (io_out !== 4'b1010) begin n_bad++; $display("FAIL io30 got=%b want=1010", io_out); end
        n_cmp++; if (oeb !== 4'b1110) begin n_bad++; $display("FAIL oeb30 got=%b want=1110", oeb); end
        n_cmp++; if (inp_dis !== 4'b0010) begin n_bad++; $display("FAIL inp30 got=%b want=0010", inp_dis); end
        n_cmp++; if (dm !== 12'h243) begin n_bad++; $display("FAIL dm30 got=%h want=243", dm); end
        tick();
    endtask

    task automatic test_sync();
        io_in = 4'b0010;
        #1;
        n_cmp++; if (user_io_in !== 4'b0010) begin n_bad++; $display("FAIL user_in got=%b want=0010", user_io_in); end
        tick();
        n_cmp++; if (mgmt_gpio_in !== 4'b0000) begin n_bad++; $display("FAIL sync_1cyc got=%b want=0000", mgmt_gpio_in); end
        tick();
        n_cmp++; if (mgmt_gpio_in !== 4'b0010) begin n_bad++; $display("FAIL sync_2cyc got=%b want=0010", mgmt_gpio_in); end
        io_in = 4'b0000;
        tick();
        tick();
    endtask

    // Load and shift in one cycle, then reset in the middle of a stream.
    task automatic test_back_to_back();
        for (int k = 0; k < NB - 1; k++) send_bit(1'b0);
        send_bit(1'b1);                  // shadow = 24'h000001
        ser_shift   = 1'b1;
        ser_data_in = 1'b1;
        ser_load    = 1'b1;
        tick();
        ser_shift = 1'b0;
        ser_load  = 1'b0;
        n_cmp++; if (cfg_applied !== 1'b1) begin n_bad++; $display("FAIL ld_sh_applied got=%b want=1", cfg_applied); end
        n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL ld_sh_busy got=%b want=0", cfg_busy); end
        // pad0 = 6'h01 (mgmt, enabled), pads 3..1 = 0 (user, enabled, dm 000).
        n_cmp++; if (dm !== 12'h000) begin n_bad++; $display("FAIL ld_sh_dm got=%h want=000", dm); end
        n_cmp++; if (oeb !== 4'b0010) begin n_bad++; $display("FAIL ld_sh_oeb got=%b want=0010", oeb); end
        for (int k = 0; k < 12; k++) send_bit(1'b1);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (oeb !== 4'hF) begin n_bad++; $display("FAIL midrst_oeb got=%h want=F", oeb); end
        n_cmp++; if (dm !== 12'h249) begin n_bad++; $display("FAIL midrst_dm got=%h want=249", dm); end
        n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", cfg_busy); end
        tick();
        reset = 1'b0;
        tick();
        for (int k = 0; k < 12; k++) send_bit(1'b1);
        n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL midrst_count got=%b want=1", cfg_busy); end
        pulse_load();
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL midrst_err got=%b want=1", cfg_err); end
        tick();
    endtask

`ifdef MPRJ_IO_PAD_CTRL_READBACK_EN
    task automatic test_readback();
        logic [NB-1:0] w;
        w = {6'h2B, 6'h0B, 6'h06, 6'h19};
        send_word(w);
        pulse_load();
        n_cmp++; if (cfg_applied !== 1'b1) begin n_bad++; $display("FAIL rb_applied got=%b want=1", cfg_applied); end
        send_word(24'hFFFFFF);           // scribble the shadow
        ser_capture = 1'b1;
        tick();
        ser_capture = 1'b0;
        n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL rb_busy got=%b want=0", cfg_busy); end
        for (int k = NB - 1; k >= 0; k--) begin
            n_cmp++;
            if (ser_data_out !== w[k]) begin
                n_bad++;
                $display("FAIL rb_bit[%0d] got=%b want=%b", k, ser_data_out, w[k]);
            end
            send_bit(1'b0);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load_ok();
        test_load_err();
        test_overshift();
        test_sync();
        test_back_to_back();
`ifdef MPRJ_IO_PAD_CTRL_READBACK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
